// File: rtl/fft16_input_loader.sv
// fft16_input_loader
// Serial-to-parallel front end of the 16-point FFT datapath. Complex samples
// arrive one per cycle over a valid/ready handshake. They are gathered into a
// 16-lane frame, and the frame is presented in parallel with an
// out_valid/out_ready handshake. One frame of skid buffering lets a complete
// frame wait while the downstream slot is still occupied.
//
// Optional build macro FFT16_IN_BITREV_EN: when defined, the sample at
// position k is placed on output lane bitrev4(k), which gives
// decimation-in-time ordering. When undefined, sample k goes to lane k.
//
// Ports
//   clk                 clock; all state changes on the rising edge
//   rst                 asynchronous, active-high reset
//   in_r / in_i         incoming sample, signed N-bit real and imaginary parts
//   in_valid            a sample is present on in_r/in_i
//   in_sync             marks the sample as lane 0 of a new frame (on accept)
//   in_ready            loader accepts a sample this cycle (decoded from state)
//   outK_r / outK_i     registered frame lanes, K = 0..15
//   out_valid           the frame on outK_* is valid
//   out_ready           downstream consumes the frame this cycle
//   sync_err            sticky flag: in_sync arrived in the middle of a frame
module fft16_input_loader #(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [N-1:0] in_r,
  input  logic signed [N-1:0] in_i,
  input  logic                in_valid,
  input  logic                in_sync,
  output logic                in_ready,
  output logic signed [N-1:0] out0_r,
  output logic signed [N-1:0] out0_i,
  output logic signed [N-1:0] out1_r,
  output logic signed [N-1:0] out1_i,
  output logic signed [N-1:0] out2_r,
  output logic signed [N-1:0] out2_i,
  output logic signed [N-1:0] out3_r,
  output logic signed [N-1:0] out3_i,
  output logic signed [N-1:0] out4_r,
  output logic signed [N-1:0] out4_i,
  output logic signed [N-1:0] out5_r,
  output logic signed [N-1:0] out5_i,
  output logic signed [N-1:0] out6_r,
  output logic signed [N-1:0] out6_i,
  output logic signed [N-1:0] out7_r,
  output logic signed [N-1:0] out7_i,
  output logic signed [N-1:0] out8_r,
  output logic signed [N-1:0] out8_i,
  output logic signed [N-1:0] out9_r,
  output logic signed [N-1:0] out9_i,
  output logic signed [N-1:0] out10_r,
  output logic signed [N-1:0] out10_i,
  output logic signed [N-1:0] out11_r,
  output logic signed [N-1:0] out11_i,
  output logic signed [N-1:0] out12_r,
  output logic signed [N-1:0] out12_i,
  output logic signed [N-1:0] out13_r,
  output logic signed [N-1:0] out13_i,
  output logic signed [N-1:0] out14_r,
  output logic signed [N-1:0] out14_i,
  output logic signed [N-1:0] out15_r,
  output logic signed [N-1:0] out15_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sync_err
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic signed [N-1:0] fill_re_r [0:15];
  logic signed [N-1:0] fill_im_r [0:15];
  logic signed [N-1:0] out_re_r  [0:15];
  logic signed [N-1:0] out_im_r  [0:15];
  logic                out_valid_r;
  logic                sync_err_r;

  logic                accept_s;
  logic                slot_free_s;

  // Output lane for the sample at frame position k. Position 15 maps to
  // lane 15 in both orderings, so fill[15] always holds the last sample.
  function automatic logic [3:0] lane_of(input logic [3:0] k);
`ifdef FFT16_IN_BITREV_EN
    lane_of = {k[0], k[1], k[2], k[3]};
`else
    lane_of = k;
`endif
  endfunction

  assign in_ready    = (state_r == FILL);
  assign accept_s    = in_valid && in_ready;
  assign slot_free_s = !out_valid_r || out_ready;

  // Frame assembly, skid buffering and output frame register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= FILL;
      cnt_r       <= 4'd0;
      out_valid_r <= 1'b0;
      sync_err_r  <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        fill_re_r[k] <= '0;
        fill_im_r[k] <= '0;
        out_re_r[k]  <= '0;
        out_im_r[k]  <= '0;
      end
    end else begin
      // A consume clears out_valid unless a load below sets it again
      // in the same cycle. This keeps back-to-back frames free of bubbles.
      if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        FILL: begin
          if (accept_s) begin
            if (in_sync && (cnt_r != 4'd0)) begin
              // Resync: drop the partial frame and restart at position 0.
              // The output frame is not touched.
              fill_re_r[0] <= in_r;
              fill_im_r[0] <= in_i;
              cnt_r        <= 4'd1;
              sync_err_r   <= 1'b1;
            end else if (cnt_r == 4'd15) begin
              cnt_r <= 4'd0;
              if (slot_free_s) begin
                // Load straight from the fill buffer plus the live sample,
                // so the frame appears on the same edge that completes it.
                for (int k = 0; k < 15; k++) begin
                  out_re_r[k] <= fill_re_r[k];
                  out_im_r[k] <= fill_im_r[k];
                end
                out_re_r[15] <= in_r;
                out_im_r[15] <= in_i;
                out_valid_r  <= 1'b1;
              end else begin
                fill_re_r[15] <= in_r;
                fill_im_r[15] <= in_i;
                state_r       <= WAIT;
              end
            end else begin
              fill_re_r[lane_of(cnt_r)] <= in_r;
              fill_im_r[lane_of(cnt_r)] <= in_i;
              cnt_r                     <= cnt_r + 4'd1;
            end
          end
        end
        WAIT: begin
          // out_valid is always set here, so out_ready alone signals a consume
          if (out_ready) begin
            for (int k = 0; k < 16; k++) begin
              out_re_r[k] <= fill_re_r[k];
              out_im_r[k] <= fill_im_r[k];
            end
            out_valid_r <= 1'b1;
            state_r     <= FILL;
          end
        end
        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign sync_err  = sync_err_r;

  assign out0_r  = out_re_r[0];
  assign out0_i  = out_im_r[0];
  assign out1_r  = out_re_r[1];
  assign out1_i  = out_im_r[1];
  assign out2_r  = out_re_r[2];
  assign out2_i  = out_im_r[2];
  assign out3_r  = out_re_r[3];
  assign out3_i  = out_im_r[3];
  assign out4_r  = out_re_r[4];
  assign out4_i  = out_im_r[4];
  assign out5_r  = out_re_r[5];
  assign out5_i  = out_im_r[5];
  assign out6_r  = out_re_r[6];
  assign out6_i  = out_im_r[6];
  assign out7_r  = out_re_r[7];
  assign out7_i  = out_im_r[7];
  assign out8_r  = out_re_r[8];
  assign out8_i  = out_im_r[8];
  assign out9_r  = out_re_r[9];
  assign out9_i  = out_im_r[9];
  assign out10_r = out_re_r[10];
  assign out10_i = out_im_r[10];
  assign out11_r = out_re_r[11];
  assign out11_i = out_im_r[11];
  assign out12_r = out_re_r[12];
  assign out12_i = out_im_r[12];
  assign out13_r = out_re_r[13];
  assign out13_i = out_im_r[13];
  assign out14_r = out_re_r[14];
  assign out14_i = out_im_r[14];
  assign out15_r = out_re_r[15];
  assign out15_i = out_im_r[15];

endmodule

// File: tb/tb_fft16_input_loader.sv
// tb_fft16_input_loader
// Directed self-checking bench for fft16_input_loader. It covers reset state,
// a single frame, continuous streaming, skid buffering under backpressure,
// mid-frame resync, and reset in the middle of a frame. When the design is
// built with FFT16_IN_BITREV_EN, lane expectations follow bit-reversed order.
module tb_fft16_input_loader;

  logic               clk;
  logic               rst;
  logic signed [15:0] in_r;
  logic signed [15:0] in_i;
  logic               in_valid;
  logic               in_sync;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic               sync_err;
  logic signed [15:0] o_r [0:15];
  logic signed [15:0] o_i [0:15];

  int checks_cnt   = 0;
  int failures_cnt = 0;

  fft16_input_loader #(.N(16)) dut (
    .clk(clk), .rst(rst),
    .in_r(in_r), .in_i(in_i), .in_valid(in_valid), .in_sync(in_sync),
    .in_ready(in_ready),
    .out0_r(o_r[0]),   .out0_i(o_i[0]),   .out1_r(o_r[1]),   .out1_i(o_i[1]),
    .out2_r(o_r[2]),   .out2_i(o_i[2]),   .out3_r(o_r[3]),   .out3_i(o_i[3]),
    .out4_r(o_r[4]),   .out4_i(o_i[4]),   .out5_r(o_r[5]),   .out5_i(o_i[5]),
    .out6_r(o_r[6]),   .out6_i(o_i[6]),   .out7_r(o_r[7]),   .out7_i(o_i[7]),
    .out8_r(o_r[8]),   .out8_i(o_i[8]),   .out9_r(o_r[9]),   .out9_i(o_i[9]),
    .out10_r(o_r[10]), .out10_i(o_i[10]), .out11_r(o_r[11]), .out11_i(o_i[11]),
    .out12_r(o_r[12]), .out12_i(o_i[12]), .out13_r(o_r[13]), .out13_i(o_i[13]),
    .out14_r(o_r[14]), .out14_i(o_i[14]), .out15_r(o_r[15]), .out15_i(o_i[15]),
    .out_valid(out_valid), .out_ready(out_ready), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output lane for frame position k
  function automatic int lane_of(input int k);
    logic [3:0] kb;
    kb = k[3:0];
`ifdef FFT16_IN_BITREV_EN
    return int'({kb[0], kb[1], kb[2], kb[3]});
`else
    return int'(kb);
`endif
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample for one clock edge, then sample 1 time unit later
  task automatic drive(input int r, input int i, input logic s);
    in_valid = 1'b1;
    in_r     = r[15:0];
    in_i     = i[15:0];
    in_sync  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sync  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_r      = 16'sd0;
    in_i      = 16'sd0;
    in_valid  = 1'b0;
    in_sync   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_sync_err", int'(sync_err), 0);
    check("rst_out0_r", int'(o_r[0]), 0);
    rst = 1'b0;

    // Test 1: a single frame with r=k, i=-k
    for (int k = 0; k < 16; k++) begin
      check("t1_in_ready", int'(in_ready), 1);
      if (k < 15) begin
        drive(k, -k, 1'b0);
        check("t1_no_early_valid", int'(out_valid), 0);
      end else begin
        drive(k, -k, 1'b0);
      end
    end
    check("t1_out_valid", int'(out_valid), 1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t1_lane_r%0d", lane_of(k)), int'(o_r[lane_of(k)]), k);
      check($sformatf("t1_lane_i%0d", lane_of(k)), int'(o_i[lane_of(k)]), -k);
    end
`ifdef FFT16_IN_BITREV_EN
    check("t6_out8_r", int'(o_r[8]), 1);
    check("t6_out4_r", int'(o_r[4]), 2);
    check("t6_out12_r", int'(o_r[12]), 3);
    check("t6_out15_r", int'(o_r[15]), 15);
    check("t6_out0_r", int'(o_r[0]), 0);
`endif
    idle();
    check("t1_valid_clears", int'(out_valid), 0);

    // Test 2: 48 samples streamed back to back, three frames, no bubbles
    for (int s = 0; s < 48; s++) begin
      check("t2_in_ready", int'(in_ready), 1);
      drive(1000 + s, s, 1'b0);
      check("t2_out_valid", int'(out_valid), ((s % 16) == 15) ? 1 : 0);
      if ((s % 16) == 15) begin
        check("t2_lane15_r", int'(o_r[15]), 1000 + s);
        check("t2_lane0_r", int'(o_r[0]), 1000 + s - 15);
      end
    end
    idle();
    check("t2_valid_clears", int'(out_valid), 0);

    // Test 3: backpressure; the second frame waits in the skid buffer
    out_ready = 1'b0;
    for (int s = 0; s < 32; s++) begin
      check("t3_in_ready", int'(in_ready), 1);
      drive(s, 50 + s, 1'b0);
    end
    in_valid = 1'b0;
    check("t3_wait_in_ready", int'(in_ready), 0);
    check("t3_hold_valid", int'(out_valid), 1);
    check("t3_hold_lane_r", int'(o_r[lane_of(5)]), 5);
    check("t3_hold_lane15_r", int'(o_r[15]), 15);
    idle();
    check("t3_still_wait", int'(in_ready), 0);
    check("t3_still_hold", int'(o_r[lane_of(3)]), 3);
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    check("t3_swap_valid", int'(out_valid), 1);
    check("t3_swap_in_ready", int'(in_ready), 1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t3_swap_r%0d", lane_of(k)), int'(o_r[lane_of(k)]), 16 + k);
    end
    check("t3_swap_i0", int'(o_i[0]), 66);
    out_ready = 1'b1;
    idle();
    check("t3_drained", int'(out_valid), 0);

    // Test 4: in_sync at cnt=0 is benign; in_sync mid-frame resyncs
    drive(200, 0, 1'b1);
    check("t4_sync_at_zero", int'(sync_err), 0);
    for (int s = 1; s < 5; s++) begin
      drive(200 + s, 0, 1'b0);
    end
    check("t4_no_err_yet", int'(sync_err), 0);
    drive(100, 7, 1'b1);
    check("t4_sync_err_set", int'(sync_err), 1);
    for (int s = 1; s < 16; s++) begin
      drive(100 + s, 7, 1'b0);
      check("t4_valid", int'(out_valid), (s == 15) ? 1 : 0);
    end
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t4_lane_r%0d", lane_of(k)), int'(o_r[lane_of(k)]), 100 + k);
    end
    idle();
    check("t4_sync_err_sticky", int'(sync_err), 1);

    // Test 5: reset after 9 samples discards the partial frame
    for (int s = 0; s < 9; s++) begin
      drive(300 + s, 1, 1'b0);
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", int'(out_valid), 0);
    check("t5_rst_out0_r", int'(o_r[0]), 0);
    check("t5_rst_out15_r", int'(o_r[15]), 0);
    check("t5_rst_sync_err", int'(sync_err), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_after_rst_valid", int'(out_valid), 0);
    for (int s = 0; s < 16; s++) begin
      drive(400 + s, -s, 1'b0);
      check("t5_valid", int'(out_valid), (s == 15) ? 1 : 0);
    end
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t5_lane_r%0d", lane_of(k)), int'(o_r[lane_of(k)]), 400 + k);
    end
    check("t5_lane_i15", int'(o_i[15]), -15);
    idle();
    check("t5_valid_clears", int'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
